// File: rtl/word_loader_pkg.sv
// Shared constants and state encoding for the byte-to-word table loader.
package word_loader_pkg;

  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simple_dpram.sv
// One write port, one registered read port; read-first on address collision.
// The array carries no reset so it maps onto plain block RAM.
module simple_dpram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem [2**AW];

  // Write and read in one block: the read samples the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/word_loader.sv
// Packs a valid/ready byte stream little-endian into 32-bit words and writes
// them to consecutive table addresses until the table is full.
//
// Handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high; byte_ready_o depends only on registered state,
// and a start_i pulse in the same cycle takes priority and drops the byte.
module word_loader #(
  parameter int DEPTH = word_loader_pkg::DEPTH,
  parameter int AW    = word_loader_pkg::AW,
  parameter int DW    = word_loader_pkg::DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   wr_cnt_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    state_o
);
  import word_loader_pkg::*;

  // Count value whose increment fills the table.
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [DW-9:0]   asm_q;
  logic [AW-1:0]   wr_addr_q;
  logic [AW:0]     wr_cnt_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_valid_q;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   ram_q;

  // The fourth byte of a word completes it and goes straight into the table.
  assign wr_en   = (state_q == LOAD) && byte_valid_i && !start_i && (idx_q == 2'd3);
  assign wr_data = {byte_i, asm_q};

  // FSM, byte index, assembly register, write address and count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      wr_cnt_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q   <= LOAD;
            idx_q     <= 2'd0;
            wr_addr_q <= '0;
            wr_cnt_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        LOAD: begin
          if (start_i) begin
            // Restart: the in-flight byte and any partial word are dropped.
            idx_q     <= 2'd0;
            wr_addr_q <= '0;
            wr_cnt_q  <= '0;
          end else if (byte_valid_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
              2'd0: asm_q[7:0]   <= byte_i;
              2'd1: asm_q[15:8]  <= byte_i;
              2'd2: asm_q[23:16] <= byte_i;
              default: begin
                wr_addr_q <= wr_addr_q + 1'b1;
                wr_cnt_q  <= wr_cnt_q + 1'b1;
                if (wr_cnt_q == LAST_CNT) begin
                  state_q <= DONE;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gates read data to zero from reset until the first post-reset read lands.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_valid_q <= 1'b0;
    else        rd_valid_q <= 1'b1;
  end

  simple_dpram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (ram_q)
  );

  assign rd_data_o    = rd_valid_q ? ram_q : '0;
  assign wr_cnt_o     = wr_cnt_q;
  assign byte_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign state_o      = state_q;

endmodule
